serial_sub: RTL and testbench
=============================

Name: serial_sub

Overview:
Parametrised multi-cycle subtractor computing d = a - b - bin over WIDTH bits, DIGIT bits per clock, with registered borrow chaining between digits. It uses a start/busy/done handshake. It is the sequential successor to the single-bit full subtractor, for area-constrained datapaths (ALU slow path, accumulator decrement) where a full-width ripple or lookahead subtractor is not wanted.

Parameters:
WIDTH, 8, operand/result width in bits; >= 1
DIGIT, 1, bits processed per clock; must divide WIDTH exactly, otherwise elaboration fails ($error in generate)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
a  input  WIDTH  minuend; sampled on the accepted start edge only
b  input  WIDTH  subtrahend; sampled on the accepted start edge only
bin  input  1  borrow-in; sampled on the accepted start edge only
busy  output  1  high while an operation is in progress (RUN)
done  output  1  single-cycle pulse: d/bout valid and newly updated
d  output  WIDTH  difference, (a - b - bin) mod 2^WIDTH
bout  output  1  borrow-out; 1 iff unsigned a < b + bin

Behaviour:
- N = WIDTH/DIGIT. FSM states: IDLE, RUN, DONE. A digit counter spans 0..N-1 (width clog2(N), minimum 1).
- Reset (async assert, sync deassert handled upstream): state=IDLE, busy=0, done=0, d=0, bout=0, counter=0, internal shift and borrow registers 0.
- IDLE: if start=1 at edge E0, latch a, b into shift registers and bin into the borrow register, clear the counter, go to RUN. Otherwise stay.
- RUN, edges E1..EN: each edge processes the lowest DIGIT bits.
  - {borrow, slice} = a_slice - b_slice - borrow, with DIGIT+1-bit arithmetic.
  - slice shifts into the result register from the MSB end; operands shift right by DIGIT.
  - At EN (counter = N-1) the final digit completes. d is loaded with the full result, bout with the final borrow, and state goes to DONE.
- DONE: done=1 for exactly one cycle (between EN and EN+1), then go to IDLE. If start=1 at EN+1, accept a new operation directly (back-to-back); minimum period is N+1 cycles.
- busy=1 exactly while in RUN (after E0 through EN); done and busy are never high together.
- Latency: start accepted at E0 -> done high in the cycle after edge E_N.
- start while busy is ignored; inputs are not re-sampled and the operation in flight is unaffected.
- a/b/bin changing after E0 have no effect.
- d and bout hold the last completed result until the next completion. They are never updated with partial results.
- rst_n asserted mid-RUN aborts the operation; all outputs return to reset values immediately and no done pulse is issued.
- WIDTH=DIGIT=1 degenerates to a registered full subtractor with 2-cycle handshake latency.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined: adds output port ovf (1 bit, reset 0), updated with d at completion. ovf = two's-complement overflow of a - b - bin, i.e. borrow into the MSB XOR borrow out of the MSB. This requires the borrow into the final bit to be captured; when DIGIT>1, compute it inside the last digit.
- Not defined: no ovf port and no associated logic.

Test Plan:
- WIDTH=8, DIGIT=1: start with a=0x05, b=0x03, bin=0 -> busy high 8 cycles; done pulse one cycle after E8 with d=0x02, bout=0.
- WIDTH=8, DIGIT=1: a=0x00, b=0x01, bin=0 -> d=0xFF, bout=1. Then a=0x10, b=0x0F, bin=1 -> d=0x00, bout=0.
- WIDTH=1, DIGIT=1: all 8 combinations of a, b, bin -> {bout,d} equals the 2-bit result of a-b-bin each time (e.g. 0,1,1 -> bout=1, d=0); done one cycle after E1.
- WIDTH=8, DIGIT=4: a=0x80, b=0x01, bin=0 -> done one cycle after E2; d=0x7F, bout=0; with SERIAL_SUB_OVF_EN, ovf=1. Also a=0x05, b=0x03 -> ovf=0.
- Handshake: pulse start again mid-RUN with different operands -> ignored, first result delivered unchanged. Hold start high through DONE -> second operation accepted at EN+1, done pulses N+1 cycles apart.
- Reset: assert rst_n=0 at RUN cycle 3 -> busy, done, d, bout are 0 immediately. After release, a fresh start (a=0xAA, b=0x55, bin=0) gives d=0x55, bout=0.

Source files
------------

// File: rtl/serial_sub_if.sv
// ----------------------------------------------------------------------------
// serial_sub_if
// Handshake and data bundle for the serial subtractor. The master drives the
// request and operands, the slave (serial_sub) returns status and the result.
// Optional macro SERIAL_SUB_OVF_EN adds the two's-complement overflow flag.
// ----------------------------------------------------------------------------
interface serial_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b, bin,
`ifdef SERIAL_SUB_OVF_EN
        input  ovf,
`endif
        input  busy, done, d, bout
    );

    modport slave (
        input  start, a, b, bin,
`ifdef SERIAL_SUB_OVF_EN
        output ovf,
`endif
        output busy, done, d, bout
    );
endinterface

// File: rtl/serial_sub.sv
// ----------------------------------------------------------------------------
// serial_sub
// Multi-cycle subtractor: d = a - b - bin over WIDTH bits, DIGIT bits per
// clock, with the borrow carried between digits in a register.
// Handshake: start (accepted in IDLE or DONE), busy (high in RUN), done
// (one-cycle pulse when d/bout are freshly loaded).
// Optional feature macro: SERIAL_SUB_OVF_EN -- adds the ovf output, the
// two's-complement overflow of the whole subtraction.
// ----------------------------------------------------------------------------
module serial_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    serial_sub_if.slave bus
);

    // Number of digits per operation and the counter that walks them.
    localparam int N  = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
    localparam int REM = (DIGIT > 0) ? (WIDTH % DIGIT) : 1;

    // Reject configurations where the digits do not tile the word exactly.
    generate
        if ((WIDTH < 1) || (DIGIT < 1) || (REM != 0)) begin : g_bad_cfg
            $error("serial_sub: DIGIT=%0d must be >= 1 and divide WIDTH=%0d", DIGIT, WIDTH);
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // One digit of the subtraction in DIGIT+1 bits; the top bit is the
    // borrow out of the digit (the result wraps negative exactly when the
    // subtrahend plus borrow exceeds the minuend slice).
    function automatic logic [DIGIT:0] digit_sub(
        input logic [DIGIT-1:0] x,
        input logic [DIGIT-1:0] y,
        input logic             c
    );
        logic [DIGIT:0] r;
        r = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, c};
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;     // minuend, shifted right one digit per step
    logic [WIDTH-1:0] b_sh_q;     // subtrahend, shifted alongside
    logic [WIDTH-1:0] res_q;      // partial result, filled from the MSB end
    logic             brw_q;      // borrow into the current digit
    logic [CW-1:0]    cnt_q;      // index of the digit being processed
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] d_q;        // last completed difference
    logic             bout_q;     // last completed borrow-out
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q;
`endif

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [DIGIT:0]         dig_s;      // {borrow_out, diff_slice} of the current digit
    logic [WIDTH+DIGIT-1:0] res_cat_s;  // new slice stacked above the partial result
    logic [WIDTH-1:0]       res_nxt_s;  // partial result after this digit
    logic                   last_s;     // current digit is the most significant one

    // Digit arithmetic and the shift of the new slice into the result.
    always_comb begin
        dig_s     = digit_sub(a_sh_q[DIGIT-1:0], b_sh_q[DIGIT-1:0], brw_q);
        res_cat_s = {dig_s[DIGIT-1:0], res_q};
        res_nxt_s = res_cat_s[WIDTH+DIGIT-1:DIGIT];
        if (cnt_q == LAST_CNT) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Borrow into the MSB of the word. With one-bit digits it is simply the
    // registered borrow; with wider digits it comes from the low DIGIT-1 bits
    // of the last digit, evaluated alongside the full digit.
    logic msb_bin_s;
    generate
        if (DIGIT == 1) begin : g_msb_b1
            assign msb_bin_s = brw_q;
        end else begin : g_msb_bn
            logic [DIGIT-1:0] low_s;
            assign low_s = {1'b0, a_sh_q[DIGIT-2:0]}
                         - {1'b0, b_sh_q[DIGIT-2:0]}
                         - {{(DIGIT-1){1'b0}}, brw_q};
            assign msb_bin_s = low_s[DIGIT-1];
        end
    endgenerate
`endif

    // Control FSM and datapath: accept, step one digit per clock, publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= {WIDTH{1'b0}};
            b_sh_q  <= {WIDTH{1'b0}};
            res_q   <= {WIDTH{1'b0}};
            brw_q   <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            d_q     <= {WIDTH{1'b0}};
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            // done is a single-cycle pulse unless the last digit sets it.
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        // Operands and borrow are captured only here; later
                        // changes on the bus have no effect on this run.
                        a_sh_q  <= bus.a;
                        b_sh_q  <= bus.b;
                        brw_q   <= bus.bin;
                        res_q   <= {WIDTH{1'b0}};
                        cnt_q   <= {CW{1'b0}};
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    // start is ignored here: the run in flight completes.
                    a_sh_q <= a_sh_q >> DIGIT;
                    b_sh_q <= b_sh_q >> DIGIT;
                    res_q  <= res_nxt_s;
                    brw_q  <= dig_s[DIGIT];
                    if (last_s) begin
                        // Only the complete result ever reaches d/bout.
                        d_q     <= res_nxt_s;
                        bout_q  <= dig_s[DIGIT];
`ifdef SERIAL_SUB_OVF_EN
                        ovf_q   <= msb_bin_s ^ dig_s[DIGIT];
`endif
                        cnt_q   <= {CW{1'b0}};
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q   <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a quiet IDLE.
                    busy_q  <= 1'b0;
                    cnt_q   <= {CW{1'b0}};
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs come straight from registers.
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.d    = d_q;
    assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// ----------------------------------------------------------------------------
// tb_serial_sub
// Scoreboard bench for serial_sub. Three instances share clock and reset:
// WIDTH=8/DIGIT=1, WIDTH=1/DIGIT=1 and WIDTH=8/DIGIT=4. Directed vectors push
// hand-computed results into per-instance queues; a monitor pops and compares
// on every done pulse. Honours SERIAL_SUB_OVF_EN for the ovf output.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_sub;

    typedef struct {
        logic [7:0] d;
        logic       bout;
        logic       ovf;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    exp_t q8[$];
    exp_t q1[$];
    exp_t q4[$];

    // {bout,d} and ovf for a,b,bin = index bits [2],[1],[0] on the 1-bit unit
    logic [1:0] w1_exp [8] = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};
    logic       w1_ovf [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    always #5 clk = ~clk;

    serial_sub_if #(.WIDTH(8)) if8 ();
    serial_sub_if #(.WIDTH(1)) if1 ();
    serial_sub_if #(.WIDTH(8)) if4 ();

    serial_sub #(.WIDTH(8), .DIGIT(1)) u_w8d1 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    serial_sub #(.WIDTH(1), .DIGIT(1)) u_w1d1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    serial_sub #(.WIDTH(8), .DIGIT(4)) u_w8d4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

    logic o8, o1, o4;
`ifdef SERIAL_SUB_OVF_EN
    assign o8 = if8.ovf;
    assign o1 = if1.ovf;
    assign o4 = if4.ovf;
`else
    assign o8 = 1'b0;
    assign o1 = 1'b0;
    assign o4 = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic set_in(input int sel, input logic st, input logic [7:0] a,
                          input logic [7:0] b, input logic bi);
        case (sel)
            0: begin if8.start = st; if8.a = a;    if8.b = b;    if8.bin = bi; end
            1: begin if1.start = st; if1.a = a[0]; if1.b = b[0]; if1.bin = bi; end
            default: begin if4.start = st; if4.a = a; if4.b = b; if4.bin = bi; end
        endcase
    endtask

    function automatic logic get_done(input int sel);
        case (sel)
            0: return if8.done;
            1: return if1.done;
            default: return if4.done;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0: return if8.busy;
            1: return if1.busy;
            default: return if4.busy;
        endcase
    endfunction

    task automatic push(input int sel, input logic [7:0] d, input logic bo, input logic ov);
        exp_t e;
        e.d = d; e.bout = bo; e.ovf = ov;
        case (sel)
            0: q8.push_back(e);
            1: q1.push_back(e);
            default: q4.push_back(e);
        endcase
    endtask

    // Drive start for exactly one accepting edge; returns at edge + 1.
    task automatic issue(input int sel, input logic [7:0] a, input logic [7:0] b, input logic bi);
        set_in(sel, 1'b1, a, b, bi);
        @(posedge clk); #1;
        set_in(sel, 1'b0, a, b, bi);
    endtask

    // Count edges until done is seen (bounded) and busy samples on the way.
    task automatic wait_done(input int sel, output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!get_done(sel) && lat < 40) begin
            if (get_busy(sel)) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        if (!get_done(sel)) lat = -1;
    endtask

    task automatic check_pop(input int sel, input logic [7:0] d, input logic bo,
                             input logic ov, input logic bsy);
        exp_t  e;
        logic  got;
        string nm;
        got = 1'b0;
        nm  = (sel == 0) ? "w8d1" : ((sel == 1) ? "w1d1" : "w8d4");
        case (sel)
            0: if (q8.size() > 0) begin e = q8.pop_front(); got = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
            default: if (q4.size() > 0) begin e = q4.pop_front(); got = 1'b1; end
        endcase
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s_unexpected_done: got done=1 required no pending result", nm);
        end else begin
            chk({nm, "_d"}, {24'd0, d}, {24'd0, e.d});
            chk({nm, "_bout"}, {31'd0, bo}, {31'd0, e.bout});
`ifdef SERIAL_SUB_OVF_EN
            chk({nm, "_ovf"}, {31'd0, ov}, {31'd0, e.ovf});
`endif
            chk({nm, "_busy_with_done"}, {31'd0, bsy}, 32'd0);
        end
    endtask

    // Scoreboard monitor: compare every completed result against the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (if8.done) check_pop(0, if8.d, if8.bout, o8, if8.busy);
            if (if1.done) check_pop(1, {7'd0, if1.d}, if1.bout, o1, if1.busy);
            if (if4.done) check_pop(2, if4.d, if4.bout, o4, if4.busy);
        end
    end

    // Hard stop in case something wedges the stimulus thread.
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion required summary before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int bcnt;
        int gap;
        logic [2:0] v;

        set_in(0, 1'b0, 8'h00, 8'h00, 1'b0);
        set_in(1, 1'b0, 8'h00, 8'h00, 1'b0);
        set_in(2, 1'b0, 8'h00, 8'h00, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {29'd0, if8.busy, if1.busy, if4.busy}, 32'd0);
        chk("rst_done", {29'd0, if8.done, if1.done, if4.done}, 32'd0);
        chk("rst_d8",   {24'd0, if8.d}, 32'd0);
        chk("rst_bout", {29'd0, if8.bout, if1.bout, if4.bout}, 32'd0);
        chk("rst_ovf",  {29'd0, o8, o1, o4}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 0x05 - 0x03: busy for 8 cycles, done after E8
        push(0, 8'h02, 1'b0, 1'b0);
        issue(0, 8'h05, 8'h03, 1'b0);
        wait_done(0, lat, bcnt);
        chk("w8d1_lat_a", lat, 32'd8);
        chk("w8d1_busy_cycles", bcnt, 32'd8);
        @(posedge clk); #1;
        chk("w8d1_done_one_cycle", {31'd0, if8.done}, 32'd0);

        // 0x00 - 0x01 wraps with borrow; 0x10 - 0x0F - 1 is exactly zero
        push(0, 8'hFF, 1'b1, 1'b0);
        issue(0, 8'h00, 8'h01, 1'b0);
        wait_done(0, lat, bcnt);
        chk("w8d1_lat_b", lat, 32'd8);
        @(posedge clk); #1;
        push(0, 8'h00, 1'b0, 1'b0);
        issue(0, 8'h10, 8'h0F, 1'b1);
        wait_done(0, lat, bcnt);
        chk("w8d1_lat_c", lat, 32'd8);
        @(posedge clk); #1;

        // start pulsed mid-run with other operands must be ignored
        push(0, 8'h02, 1'b0, 1'b0);
        issue(0, 8'h05, 8'h03, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        set_in(0, 1'b1, 8'hFF, 8'h00, 1'b1);
        @(posedge clk); #1;
        set_in(0, 1'b0, 8'hFF, 8'h00, 1'b1);
        wait_done(0, lat, bcnt);
        chk("w8d1_lat_ignore", lat, 32'd5);
        @(posedge clk); #1;

        // Back-to-back: start held through DONE accepts the next operation
        push(0, 8'h10, 1'b0, 1'b0);
        push(0, 8'hFF, 1'b1, 1'b0);
        set_in(0, 1'b1, 8'h20, 8'h10, 1'b0);
        @(posedge clk); #1;
        set_in(0, 1'b1, 8'h01, 8'h02, 1'b0);
        wait_done(0, lat, bcnt);
        chk("w8d1_lat_b2b_first", lat, 32'd8);
        @(posedge clk); #1;
        set_in(0, 1'b0, 8'h01, 8'h02, 1'b0);
        gap = 1;
        wait_done(0, lat, bcnt);
        gap += lat;
        chk("w8d1_b2b_gap", gap, 32'd9);
        @(posedge clk); #1;

        // Reset during RUN cycle 3 clears outputs at once, no done pulse
        issue(0, 8'h33, 8'h11, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, if8.busy}, 32'd0);
        chk("midrst_done", {31'd0, if8.done}, 32'd0);
        chk("midrst_d",    {24'd0, if8.d}, 32'd0);
        chk("midrst_bout", {31'd0, if8.bout}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        push(0, 8'h55, 1'b0, 1'b1);
        issue(0, 8'hAA, 8'h55, 1'b0);
        wait_done(0, lat, bcnt);
        chk("w8d1_lat_after_rst", lat, 32'd8);
        @(posedge clk); #1;

        // WIDTH=1: full-subtractor truth table
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            push(1, {7'd0, w1_exp[i][0]}, w1_exp[i][1], w1_ovf[i]);
            issue(1, {7'd0, v[2]}, {7'd0, v[1]}, v[0]);
            wait_done(1, lat, bcnt);
            chk("w1d1_lat", lat, 32'd1);
            @(posedge clk); #1;
        end

        // WIDTH=8, DIGIT=4: two digits per operation
        push(2, 8'h7F, 1'b0, 1'b1);
        issue(2, 8'h80, 8'h01, 1'b0);
        wait_done(2, lat, bcnt);
        chk("w8d4_lat_a", lat, 32'd2);
        @(posedge clk); #1;
        push(2, 8'h02, 1'b0, 1'b0);
        issue(2, 8'h05, 8'h03, 1'b0);
        wait_done(2, lat, bcnt);
        chk("w8d4_lat_b", lat, 32'd2);
        @(posedge clk); #1;

        // Every expected result must have been delivered
        repeat (3) @(posedge clk);
        #1;
        chk("q8_drained", q8.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        chk("q4_drained", q4.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
